inst_sequencer: RTL

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/inst_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/inst_sequencer.sv
// Program-buffer instruction sequencer: replays stored {inst, in_bus} pairs to a
// core over a valid/ready handshake, with an optional idle gap after each transfer.
module inst_sequencer #(
  parameter int INST_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int GAP    = 3,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [INST_W-1:0] ld_inst,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  input  logic              loop_mode,
  input  logic              abort,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [DATA_W-1:0] in_bus,
  output logic              inst_valid,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     pc
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int          CW      = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW:0]       len_q, len_d;
  logic              loop_q, loop_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] in_bus_q, in_bus_d;
  logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic              last, advance;

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  // Buffer is deliberately not reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (!rst && ld_en && state_q == IDLE) begin
      mem_inst[ld_addr] <= ld_inst;
      mem_data[ld_addr] <= ld_data;
    end
  end

  assign last = ({1'b0, pc_q} == len_q - (AW+1)'(1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    case (state_q)
      IDLE: if (start && prog_len != '0) begin
        len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
        loop_d  = loop_mode;
        pc_d    = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (abort) state_d = IDLE;
        else if (inst_ready) begin
          if (GAP > 0) begin
            state_d = WAIT;
            cnt_d   = CW'(GAP - 1);
          end else begin
            advance = 1'b1;
          end
        end
      end
      WAIT: begin
        if (abort) state_d = IDLE;
        else if (cnt_q == '0) advance = 1'b1;
        else cnt_d = cnt_q - CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (!last) begin
        pc_d    = pc_q + AW'(1);
        state_d = ISSUE;
      end else if (loop_q) begin
        pc_d    = '0;
        state_d = ISSUE;
      end else begin
        state_d = DONE;
      end
    end

    // Outputs are registered from the next state so they align with state_q.
    valid_d  = (state_d == ISSUE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    inst_d   = valid_d ? mem_inst[pc_d] : '0;
    in_bus_d = valid_d ? mem_data[pc_d] : in_bus_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      cnt_q    <= '0;
      inst_q   <= '0;
      in_bus_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      cnt_q    <= cnt_d;
      inst_q   <= inst_d;
      in_bus_q <= in_bus_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign inst       = inst_q;
  assign in_bus     = in_bus_q;
  assign inst_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pc         = pc_q;

endmodule
